// File: rtl/pwm_fade_pkg.sv
// Shared types and register map for the PWM duty fade sequencer.
package pwm_fade_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 4;

  localparam logic [REG_ADDR_WIDTH-1:0] GPIO_OUT_ADDR   = 4'h0;
  localparam logic [REG_ADDR_WIDTH-1:0] GPIO_IN_ADDR    = 4'h4;
  localparam logic [REG_ADDR_WIDTH-1:0] PWM_DUTY_ADDR   = 4'h8;
  localparam logic [REG_ADDR_WIDTH-1:0] PWM_PERIOD_ADDR = 4'hC;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } fade_state_e;

endpackage

// File: rtl/pwm_fade_step.sv
// Saturating single step of cur toward to by at most step; never overshoots or wraps.
module pwm_fade_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] cur,
  input  logic [DATA_WIDTH-1:0] to,
  input  logic [DATA_WIDTH-1:0] step,
  output logic [DATA_WIDTH-1:0] next_c
);

  logic [DATA_WIDTH-1:0] diff;

  always_comb begin
    diff   = '0;
    next_c = to;
    // Comparing the remaining distance first keeps cur +/- step inside [min(cur,to), max(cur,to)].
    if (cur < to) begin
      diff   = to - cur;
      next_c = (diff <= step) ? to : cur + step;
    end else if (cur > to) begin
      diff   = cur - to;
      next_c = (diff <= step) ? to : cur - step;
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM duty fade sequencer sharing the regfile write port with the bus (bus has priority).
// Optional PWM_FADE_ABORT_EN: a bus write to the duty register cancels a running fade.
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET_N,
  input  logic                  bus_write_en,
  input  logic [ADDR_WIDTH-1:0] bus_write_addr,
  input  logic [DATA_WIDTH-1:0] bus_write_data,
  input  logic                  fade_start,
  input  logic [DATA_WIDTH-1:0] fade_from,
  input  logic [DATA_WIDTH-1:0] fade_to,
  input  logic [DATA_WIDTH-1:0] fade_step,
  input  logic [CNT_WIDTH-1:0]  fade_interval,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  fade_busy,
  output logic                  fade_done,
  output logic                  fade_abort
);

  fade_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] from_q, from_d;
  logic [DATA_WIDTH-1:0] to_q, to_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [CNT_WIDTH-1:0]  interval_q, interval_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  write_en_q, write_en_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] next_duty_c;
  logic [DATA_WIDTH-1:0] pend_val_c;
  logic                  abort_c;

  pwm_fade_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .cur    (cur_q),
    .to     (to_q),
    .step   (step_q),
    .next_c (next_duty_c)
  );

`ifdef PWM_FADE_ABORT_EN
  logic abort_q;
  logic duty_hit_c;

  assign duty_hit_c = bus_write_en && (bus_write_addr == ADDR_WIDTH'(PWM_DUTY_ADDR));
  // Only a fade that still has writes outstanding can be cancelled.
  assign abort_c    = duty_hit_c && (state_q inside {LOAD, ISSUE, WAIT});

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_c;
    end
  end

  assign fade_abort = abort_q;
`else
  assign abort_c    = 1'b0;
  assign fade_abort = 1'b0;
`endif

  // A held write (ISSUE) re-issues cur_q; a write maturing out of WAIT uses the fresh step.
  assign pend_val_c = (state_q == ISSUE) ? cur_q : next_duty_c;

  always_comb begin
    state_d      = state_q;
    from_d       = from_q;
    to_d         = to_q;
    step_d       = step_q;
    cur_d        = cur_q;
    interval_d   = interval_q;
    cnt_d        = cnt_q;
    write_en_d   = 1'b0;
    write_addr_d = '0;
    write_data_d = '0;

    if (bus_write_en) begin
      write_en_d   = 1'b1;
      write_addr_d = bus_write_addr;
      write_data_d = bus_write_data;
    end

    if (abort_c) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fade_start) begin
            from_d     = fade_from;
            to_d       = fade_to;
            step_d     = (fade_step == '0) ? DATA_WIDTH'(1) : fade_step;
            interval_d = (fade_interval == '0) ? CNT_WIDTH'(1) : fade_interval;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          cur_d   = from_q;
          state_d = ISSUE;
        end
        ISSUE, WAIT: begin
          if ((state_q == WAIT) && (cnt_q > CNT_WIDTH'(1))) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end else if (bus_write_en) begin
            // Bus owns the port this cycle; park the pending value unchanged.
            cur_d   = pend_val_c;
            state_d = ISSUE;
          end else begin
            write_en_d   = 1'b1;
            write_addr_d = ADDR_WIDTH'(PWM_DUTY_ADDR);
            write_data_d = pend_val_c;
            cur_d        = pend_val_c;
            cnt_d        = interval_q;
            state_d      = (pend_val_c == to_q) ? DONE : WAIT;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      state_q      <= IDLE;
      from_q       <= '0;
      to_q         <= '0;
      step_q       <= '0;
      cur_q        <= '0;
      interval_q   <= '0;
      cnt_q        <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      from_q       <= from_d;
      to_q         <= to_d;
      step_q       <= step_d;
      cur_q        <= cur_d;
      interval_q   <= interval_d;
      cnt_q        <= cnt_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign fade_busy  = busy_q;
  assign fade_done  = done_q;

endmodule
